// File: rtl/laser_pkg.sv
// Shared constants and FSM encoding for the laser cover evaluator.
package laser_pkg;

  localparam int unsigned NPTS      = 40;
  localparam int unsigned CW        = 4;
  localparam int unsigned RADIUS_SQ = 16;
  localparam int unsigned NW        = $clog2(NPTS + 1);
  localparam int unsigned IW        = $clog2(NPTS);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWait,
    StEval,
    StResp
  } state_e;

endpackage

// File: rtl/laser_in_circle.sv
// Combinational point-in-circle test: (px-cx)^2 + (py-cy)^2 <= RADIUS_SQ.
module laser_in_circle
  import laser_pkg::*;
(
  input  logic [CW-1:0] px,
  input  logic [CW-1:0] py,
  input  logic [CW-1:0] cx,
  input  logic [CW-1:0] cy,
  output logic          hit
);

  logic [CW-1:0]   dx;
  logic [CW-1:0]   dy;
  logic [2*CW-1:0] dx_sq;
  logic [2*CW-1:0] dy_sq;
  logic [2*CW:0]   dist_sq;

  // Absolute differences, squares and sum; 2*CW+1 bits cannot overflow.
  always_comb begin
    dx      = (px >= cx) ? (px - cx) : (cx - px);
    dy      = (py >= cy) ? (py - cy) : (cy - py);
    dx_sq   = {{CW{1'b0}}, dx} * {{CW{1'b0}}, dx};
    dy_sq   = {{CW{1'b0}}, dy} * {{CW{1'b0}}, dy};
    dist_sq = {1'b0, dx_sq} + {1'b0, dy_sq};
    hit     = (dist_sq <= (2 * CW + 1)'(RADIUS_SQ));
  end

endmodule

// File: rtl/laser_cover_eval.sv
// Scorer for the two-circle laser placement engine: stores the 40-point frame, latches the
// engine's centres on DONE, counts covered points one per cycle and offers the result over a
// valid/ready handshake.
// Optional feature: define LASER_COVER_OVERLAP_EN to build the overlap (in1 & in2) counter;
// otherwise CNT_OV is tied to zero.
module laser_cover_eval
  import laser_pkg::*;
(
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          PT_VALID,
  input  logic [CW-1:0] X,
  input  logic [CW-1:0] Y,
  input  logic          DONE,
  input  logic [CW-1:0] C1X,
  input  logic [CW-1:0] C1Y,
  input  logic [CW-1:0] C2X,
  input  logic [CW-1:0] C2Y,
  output logic          RES_VALID,
  input  logic          RES_READY,
  output logic [NW-1:0] CNT1,
  output logic [NW-1:0] CNT2,
  output logic [NW-1:0] CNT_U,
  output logic [NW-1:0] CNT_OV,
  output logic          BUSY
);

  state_e state_q, state_d;

  logic [CW-1:0] px_q [NPTS];
  logic [CW-1:0] py_q [NPTS];
  logic [IW-1:0] idx_q;
  logic [CW-1:0] c1x_q, c1y_q, c2x_q, c2y_q;
  logic [NW-1:0] cnt1_q, cnt2_q, cntu_q;

  logic idx_last;
  logic load_pt;
  logic latch_ctr;
  logic eval_pt;
  logic hit1;
  logic hit2;

  assign idx_last = (idx_q == IW'(NPTS - 1));

  laser_in_circle u_circle1 (
    .px  (px_q[idx_q]),
    .py  (py_q[idx_q]),
    .cx  (c1x_q),
    .cy  (c1y_q),
    .hit (hit1)
  );

  laser_in_circle u_circle2 (
    .px  (px_q[idx_q]),
    .py  (py_q[idx_q]),
    .cx  (c2x_q),
    .cy  (c2y_q),
    .hit (hit2)
  );

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath strobes; stray PT_VALID/DONE fall through to no action.
  always_comb begin
    state_d   = state_q;
    load_pt   = 1'b0;
    latch_ctr = 1'b0;
    eval_pt   = 1'b0;
    case (state_q)
      StIdle: begin
        if (PT_VALID) begin
          load_pt = 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (PT_VALID) begin
          load_pt = 1'b1;
          if (idx_last) state_d = StWait;
        end
      end
      StWait: begin
        if (DONE) begin
          latch_ctr = 1'b1;
          state_d   = StEval;
        end
      end
      StEval: begin
        eval_pt = 1'b1;
        if (idx_last) state_d = StResp;
      end
      StResp: begin
        if (RES_READY) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Point RAM, index counter, centre latches and the always-built accumulators.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NPTS; i++) begin
        px_q[i] <= '0;
        py_q[i] <= '0;
      end
      idx_q  <= '0;
      c1x_q  <= '0;
      c1y_q  <= '0;
      c2x_q  <= '0;
      c2y_q  <= '0;
      cnt1_q <= '0;
      cnt2_q <= '0;
      cntu_q <= '0;
    end else if (load_pt) begin
      px_q[idx_q] <= X;
      py_q[idx_q] <= Y;
      idx_q       <= idx_last ? '0 : idx_q + IW'(1);
    end else if (latch_ctr) begin
      c1x_q  <= C1X;
      c1y_q  <= C1Y;
      c2x_q  <= C2X;
      c2y_q  <= C2Y;
      cnt1_q <= '0;
      cnt2_q <= '0;
      cntu_q <= '0;
      idx_q  <= '0;
    end else if (eval_pt) begin
      cnt1_q <= cnt1_q + NW'(hit1);
      cnt2_q <= cnt2_q + NW'(hit2);
      cntu_q <= cntu_q + NW'(hit1 | hit2);
      idx_q  <= idx_last ? '0 : idx_q + IW'(1);
    end
  end

`ifdef LASER_COVER_OVERLAP_EN
  logic [NW-1:0] cnto_q;

  // Overlap accumulator, cleared and stepped in lockstep with the others.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnto_q <= '0;
    end else if (latch_ctr) begin
      cnto_q <= '0;
    end else if (eval_pt) begin
      cnto_q <= cnto_q + NW'(hit1 & hit2);
    end
  end

  assign CNT_OV = cnto_q;
`else
  assign CNT_OV = '0;
`endif

  assign CNT1      = cnt1_q;
  assign CNT2      = cnt2_q;
  assign CNT_U     = cntu_q;
  assign RES_VALID = (state_q == StResp);
  assign BUSY      = (state_q != StIdle);

endmodule

// File: tb/tb_laser_cover_eval.sv
// Directed bench for laser_cover_eval. Overlap expectations follow LASER_COVER_OVERLAP_EN.
module tb_laser_cover_eval;
  import laser_pkg::*;

`ifdef LASER_COVER_OVERLAP_EN
  localparam bit OvEn = 1'b1;
`else
  localparam bit OvEn = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          PT_VALID = 1'b0;
  logic [CW-1:0] X = '0, Y = '0;
  logic          DONE = 1'b0;
  logic [CW-1:0] C1X = '0, C1Y = '0, C2X = '0, C2Y = '0;
  logic          RES_READY = 1'b0;
  logic          RES_VALID, BUSY;
  logic [NW-1:0] CNT1, CNT2, CNT_U, CNT_OV;

  logic [CW-1:0] fx [NPTS];
  logic [CW-1:0] fy [NPTS];
  int n_chk = 0;
  int n_pass = 0;

  laser_cover_eval dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .PT_VALID  (PT_VALID),
    .X         (X),
    .Y         (Y),
    .DONE      (DONE),
    .C1X       (C1X),
    .C1Y       (C1Y),
    .C2X       (C2X),
    .C2Y       (C2Y),
    .RES_VALID (RES_VALID),
    .RES_READY (RES_READY),
    .CNT1      (CNT1),
    .CNT2      (CNT2),
    .CNT_U     (CNT_U),
    .CNT_OV    (CNT_OV),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic fill(input logic [CW-1:0] x, input logic [CW-1:0] y);
    for (int i = 0; i < NPTS; i++) begin
      fx[i] = x;
      fy[i] = y;
    end
  endtask

  task automatic load_frame(input int n);
    for (int i = 0; i < n; i++) begin
      PT_VALID = 1'b1;
      X = fx[i];
      Y = fy[i];
      step();
    end
    PT_VALID = 1'b0;
  endtask

  task automatic pulse_done(input logic [CW-1:0] ax, input logic [CW-1:0] ay,
                            input logic [CW-1:0] bx, input logic [CW-1:0] by);
    DONE = 1'b1;
    C1X = ax; C1Y = ay; C2X = bx; C2Y = by;
    step();
    DONE = 1'b0;
  endtask

  // Counts cycles from the DONE cycle until RES_VALID; bounded at 100.
  task automatic wait_res(input bit noise, output int lat);
    lat = 1;
    while (!RES_VALID && lat < 100) begin
      if (noise) begin
        PT_VALID = 1'b1;
        X = '0;
        Y = '0;
      end
      step();
      lat++;
    end
    PT_VALID = 1'b0;
  endtask

  task automatic accept();
    RES_READY = 1'b1;
    step();
    RES_READY = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    #12;
    n_chk++; if (RES_VALID !== 1'b0) $display("FAIL rst_valid: got %b want 0", RES_VALID); else n_pass++;
    n_chk++; if (BUSY !== 1'b0) $display("FAIL rst_busy: got %b want 0", BUSY); else n_pass++;
    n_chk++; if (CNT1 !== 6'd0 || CNT2 !== 6'd0 || CNT_U !== 6'd0 || CNT_OV !== 6'd0)
      $display("FAIL rst_cnt: got %0d %0d %0d %0d want 0 0 0 0", CNT1, CNT2, CNT_U, CNT_OV);
    else n_pass++;
    step();
    RST_N = 1'b1;
    step();
  endtask

  // All points at (8,8); circle 1 on them, circle 2 far away. Duplicates each count.
  task automatic test_single_circle();
    int lat;
    fill(4'd8, 4'd8);
    load_frame(NPTS);
    n_chk++; if (BUSY !== 1'b1 || RES_VALID !== 1'b0)
      $display("FAIL t1_wait: got busy=%b valid=%b want 1 0", BUSY, RES_VALID);
    else n_pass++;
    pulse_done(4'd8, 4'd8, 4'd0, 4'd0);
    wait_res(1'b0, lat);
    n_chk++; if (lat != 41) $display("FAIL t1_latency: got %0d want 41", lat); else n_pass++;
    n_chk++; if (CNT1 !== 6'd40) $display("FAIL t1_cnt1: got %0d want 40", CNT1); else n_pass++;
    n_chk++; if (CNT2 !== 6'd0) $display("FAIL t1_cnt2: got %0d want 0", CNT2); else n_pass++;
    n_chk++; if (CNT_U !== 6'd40) $display("FAIL t1_cntu: got %0d want 40", CNT_U); else n_pass++;
    n_chk++; if (CNT_OV !== 6'd0) $display("FAIL t1_cntov: got %0d want 0", CNT_OV); else n_pass++;
    accept();
    n_chk++; if (RES_VALID !== 1'b0 || BUSY !== 1'b0)
      $display("FAIL t1_idle: got valid=%b busy=%b want 0 0", RES_VALID, BUSY);
    else n_pass++;
    n_chk++; if (CNT1 !== 6'd40) $display("FAIL t1_held: got %0d want 40", CNT1); else n_pass++;
  endtask

  // Radius edge: (4,0) and (0,4) are 16 (in); (3,3)=18 and (5,0)=25 are out.
  task automatic set_edge_frame();
    fill(4'd15, 4'd15);
    fx[0] = 4'd4; fy[0] = 4'd0;
    fx[1] = 4'd3; fy[1] = 4'd3;
    fx[2] = 4'd5; fy[2] = 4'd0;
    fx[3] = 4'd0; fy[3] = 4'd4;
  endtask

  task automatic test_radius_edge();
    int lat;
    set_edge_frame();
    load_frame(NPTS);
    pulse_done(4'd0, 4'd0, 4'd0, 4'd0);
    wait_res(1'b0, lat);
    n_chk++; if (CNT1 !== 6'd2 || CNT2 !== 6'd2 || CNT_U !== 6'd2)
      $display("FAIL t2_cnt: got %0d %0d %0d want 2 2 2", CNT1, CNT2, CNT_U);
    else n_pass++;
    n_chk++; if (CNT_OV !== (OvEn ? 6'd2 : 6'd0))
      $display("FAIL t2_cntov: got %0d want %0d", CNT_OV, OvEn ? 2 : 0);
    else n_pass++;
    accept();
  endtask

  // C1=(4,4), C2=(8,4). in1: (6,4),(2,4),(4,4); in2: (6,4),(10,4),(4,4),(12,4).
  task automatic test_union_hold();
    int lat;
    bit ok;
    fill(4'd15, 4'd0);
    fx[0] = 4'd6;  fy[0] = 4'd4;
    fx[1] = 4'd2;  fy[1] = 4'd4;
    fx[2] = 4'd10; fy[2] = 4'd4;
    fx[3] = 4'd4;  fy[3] = 4'd4;
    fx[4] = 4'd12; fy[4] = 4'd4;
    fx[5] = 4'd0;  fy[5] = 4'd0;
    load_frame(NPTS);
    pulse_done(4'd4, 4'd4, 4'd8, 4'd4);
    wait_res(1'b0, lat);
    n_chk++; if (lat != 41) $display("FAIL t3_latency: got %0d want 41", lat); else n_pass++;
    n_chk++; if (CNT1 !== 6'd3) $display("FAIL t3_cnt1: got %0d want 3", CNT1); else n_pass++;
    n_chk++; if (CNT2 !== 6'd4) $display("FAIL t3_cnt2: got %0d want 4", CNT2); else n_pass++;
    n_chk++; if (CNT_U !== 6'd5) $display("FAIL t3_cntu: got %0d want 5", CNT_U); else n_pass++;
    n_chk++; if (CNT_OV !== (OvEn ? 6'd2 : 6'd0))
      $display("FAIL t3_cntov: got %0d want %0d", CNT_OV, OvEn ? 2 : 0);
    else n_pass++;
    // Hold off the consumer while poking the inputs; everything must stay frozen.
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      PT_VALID = i[0];
      DONE = ~i[0];
      X = 4'd4; Y = 4'd4;
      step();
      ok &= (RES_VALID === 1'b1) && (CNT1 === 6'd3) && (CNT2 === 6'd4) && (CNT_U === 6'd5)
            && (CNT_OV === (OvEn ? 6'd2 : 6'd0));
    end
    PT_VALID = 1'b0;
    DONE = 1'b0;
    n_chk++; if (!ok) $display("FAIL t3_hold: got stable=%b want 1", ok); else n_pass++;
    accept();
    n_chk++; if (RES_VALID !== 1'b0 || BUSY !== 1'b0)
      $display("FAIL t3_idle: got valid=%b busy=%b want 0 0", RES_VALID, BUSY);
    else n_pass++;
  endtask

  // Early DONE pulses (mid-load and on the last point) carry decoy centres (0,0); stray
  // points in WAIT/EVAL are (0,0) and would drop the count if stored.
  task automatic test_done_ignored();
    int lat;
    fill(4'd8, 4'd8);
    for (int i = 0; i < NPTS; i++) begin
      PT_VALID = 1'b1;
      X = fx[i];
      Y = fy[i];
      DONE = (i == 10) || (i == NPTS - 1);
      C1X = '0; C1Y = '0; C2X = '0; C2Y = '0;
      step();
    end
    PT_VALID = 1'b0;
    DONE = 1'b0;
    n_chk++; if (BUSY !== 1'b1 || RES_VALID !== 1'b0)
      $display("FAIL t4_wait: got busy=%b valid=%b want 1 0", BUSY, RES_VALID);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      PT_VALID = 1'b1;
      X = '0;
      Y = '0;
      step();
    end
    PT_VALID = 1'b0;
    n_chk++; if (RES_VALID !== 1'b0) $display("FAIL t4_stray: got valid=%b want 0", RES_VALID);
    else n_pass++;
    pulse_done(4'd8, 4'd8, 4'd8, 4'd8);
    wait_res(1'b1, lat);
    n_chk++; if (lat != 41) $display("FAIL t4_latency: got %0d want 41", lat); else n_pass++;
    n_chk++; if (CNT1 !== 6'd40 || CNT2 !== 6'd40 || CNT_U !== 6'd40)
      $display("FAIL t4_cnt: got %0d %0d %0d want 40 40 40", CNT1, CNT2, CNT_U);
    else n_pass++;
    n_chk++; if (CNT_OV !== (OvEn ? 6'd40 : 6'd0))
      $display("FAIL t4_cntov: got %0d want %0d", CNT_OV, OvEn ? 40 : 0);
    else n_pass++;
    accept();
  endtask

  task automatic test_reset_mid_frame();
    int lat;
    fill(4'd8, 4'd8);
    load_frame(20);
    n_chk++; if (BUSY !== 1'b1) $display("FAIL t5_loading: got busy=%b want 1", BUSY); else n_pass++;
    RST_N = 1'b0;
    #2;
    n_chk++; if (BUSY !== 1'b0 || RES_VALID !== 1'b0)
      $display("FAIL t5_rst_state: got busy=%b valid=%b want 0 0", BUSY, RES_VALID);
    else n_pass++;
    n_chk++; if (CNT1 !== 6'd0 || CNT2 !== 6'd0 || CNT_U !== 6'd0 || CNT_OV !== 6'd0)
      $display("FAIL t5_rst_cnt: got %0d %0d %0d %0d want 0 0 0 0", CNT1, CNT2, CNT_U, CNT_OV);
    else n_pass++;
    step();
    RST_N = 1'b1;
    step();
    set_edge_frame();
    load_frame(NPTS);
    pulse_done(4'd0, 4'd0, 4'd0, 4'd0);
    wait_res(1'b0, lat);
    n_chk++; if (lat != 41) $display("FAIL t5_latency: got %0d want 41", lat); else n_pass++;
    n_chk++; if (CNT1 !== 6'd2 || CNT2 !== 6'd2 || CNT_U !== 6'd2)
      $display("FAIL t5_cnt: got %0d %0d %0d want 2 2 2", CNT1, CNT2, CNT_U);
    else n_pass++;
    n_chk++; if (CNT_OV !== (OvEn ? 6'd2 : 6'd0))
      $display("FAIL t5_cntov: got %0d want %0d", CNT_OV, OvEn ? 2 : 0);
    else n_pass++;
    accept();
  endtask

  initial begin
    test_reset();
    test_single_circle();
    test_radius_edge();
    test_union_hold();
    test_done_ignored();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
